// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared state encoding and constants for the multi-channel glitch filter
package noise_pkg;

    // bit 1 of the encoding is the debounced level
    typedef enum logic [1:0] {
        WAIT1   = 2'b00,
        CHK1    = 2'b01,
        STABLE1 = 2'b10,
        CHK0    = 2'b11
    } state_e;

    // smallest usable threshold; anything lower is clamped up to this
    localparam int THR_MIN = 2;

endpackage

// File: rtl/noise_channel.sv
// rtl/noise_channel.sv - one channel: synchroniser, debounce FSM, threshold latch, edge strobes
module noise_channel
    import noise_pkg::*;
#(
    parameter int   CNT_W   = 4,
    parameter int   SYNC    = 2,
    parameter logic INV_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] thr_i,
    input  logic             pulse_i,
    output logic             true_pulse_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [SYNC-1:0]  sync_q;
    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] thr_l_q, thr_l_d;
    logic             true_pulse_q, true_pulse_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W-1:0] cnt_inc;

    // cnt stays below thr_l, so the increment never wraps
    assign thr_eff = (thr_i < CNT_W'(THR_MIN)) ? CNT_W'(THR_MIN) : thr_i;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign s       = sync_q[SYNC-1];

    // synchroniser keeps running regardless of en so the FSM always sees fresh samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], pulse_i ^ INV_BIT};
        end
    end

    // next-state decode; strobes default low so they drop while en=0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        thr_l_d = thr_l_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en_i) begin
            case (state_q)
                WAIT1: begin
                    if (s) begin
                        state_d = CHK1;
                        cnt_d   = CNT_W'(1);
                        thr_l_d = thr_eff;
                    end
                end
                CHK1: begin
                    if (!s) begin
                        state_d = WAIT1;
                    end else if (cnt_inc == thr_l_q) begin
                        state_d = STABLE1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                STABLE1: begin
                    if (!s) begin
                        state_d = CHK0;
                        cnt_d   = CNT_W'(1);
                        thr_l_d = thr_eff;
                    end
                end
                CHK0: begin
                    if (s) begin
                        state_d = STABLE1;
                    end else if (cnt_inc == thr_l_q) begin
                        state_d = WAIT1;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = WAIT1;
            endcase
        end
        true_pulse_d = (state_d == STABLE1) || (state_d == CHK0);
    end

    // state, counter, latched threshold and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT1;
            cnt_q        <= '0;
            thr_l_q      <= '0;
            true_pulse_q <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            thr_l_q      <= thr_l_d;
            true_pulse_q <= true_pulse_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
        end
    end

    assign true_pulse_o = true_pulse_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;

endmodule

// File: rtl/multi_noise_eliminator.sv
// rtl/multi_noise_eliminator.sv - CH independent debounce channels plus a shared change flag
module multi_noise_eliminator
    import noise_pkg::*;
#(
    parameter int            CH    = 4,
    parameter int            CNT_W = 4,
    parameter int            SYNC  = 2,
    parameter logic [CH-1:0] INV   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] thr,
    input  logic [CH-1:0]    pulse,
    output logic [CH-1:0]    true_pulse,
    output logic [CH-1:0]    rise,
    output logic [CH-1:0]    fall,
    output logic             any_change
);

    // one filter per pin; INV lets active-low pins look active-high to the FSM
    for (genvar g = 0; g < CH; g++) begin : g_ch
        noise_channel #(
            .CNT_W  (CNT_W),
            .SYNC   (SYNC),
            .INV_BIT(INV[g])
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst),
            .en_i        (en),
            .thr_i       (thr),
            .pulse_i     (pulse[g]),
            .true_pulse_o(true_pulse[g]),
            .rise_o      (rise[g]),
            .fall_o      (fall[g])
        );
    end

    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_multi_noise_eliminator.sv
// tb/tb_multi_noise_eliminator.sv - randomized and directed checks against a run-length reference model
module tb_multi_noise_eliminator;

    localparam int            CH    = 4;
    localparam int            CNT_W = 4;
    localparam int            SYNC  = 2;
    localparam logic [CH-1:0] INV   = 4'b1000;
    localparam logic [CH-1:0] IDLE  = 4'b1000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b1;
    logic [CNT_W-1:0] thr = 4'd2;
    logic [CH-1:0]    pulse = IDLE;
    logic [CH-1:0]    true_pulse, rise, fall;
    logic             any_change;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: delayed view of each pin, current level, length of opposing run
    logic [SYNC-1:0] m_hist [CH];
    logic            m_lvl  [CH];
    int              m_run  [CH];
    int              m_rthr [CH];
    logic [CH-1:0]   e_tp, e_rise, e_fall;

    multi_noise_eliminator #(
        .CH(CH), .CNT_W(CNT_W), .SYNC(SYNC), .INV(INV)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .thr(thr), .pulse(pulse),
        .true_pulse(true_pulse), .rise(rise), .fall(fall), .any_change(any_change)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_hist[c] = '0;
            m_lvl[c]  = 1'b0;
            m_run[c]  = 0;
            m_rthr[c] = 0;
        end
        e_tp   = '0;
        e_rise = '0;
        e_fall = '0;
    endtask

    // one clock: the level flips once the opposite value has been seen thr times in a row
    task automatic tick();
        logic s;
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                s = m_hist[c][SYNC-1];
                m_hist[c] = {m_hist[c][SYNC-2:0], pulse[c] ^ INV[c]};
                e_rise[c] = 1'b0;
                e_fall[c] = 1'b0;
                if (en) begin
                    if (s != m_lvl[c]) begin
                        if (m_run[c] == 0) m_rthr[c] = (int'(thr) < 2) ? 2 : int'(thr);
                        m_run[c]++;
                        if (m_run[c] == m_rthr[c]) begin
                            m_lvl[c] = s;
                            m_run[c] = 0;
                            if (s) e_rise[c] = 1'b1;
                            else   e_fall[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                e_tp[c] = m_lvl[c];
            end
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [CH-1:0] p);
        rst = 1'b0;
        model_reset();
        pulse = p;
        en = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset(IDLE);
        n_tests++;
        if ({true_pulse, rise, fall, any_change} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got tp=%b r=%b f=%b any=%b want all 0", true_pulse, rise, fall, any_change);
        end
    endtask

    task automatic test_t1_step();
        int lat = 0, nrise = 0;
        thr = 4'd2;
        pulse = IDLE | 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_tests++;
            if ({true_pulse, rise, fall, any_change} !== {e_tp, e_rise, e_fall, |(e_rise | e_fall)}) begin
                n_fail++;
                $display("FAIL t1_cycle%0d got %b/%b/%b/%b want %b/%b/%b", k, true_pulse, rise, fall, any_change, e_tp, e_rise, e_fall);
            end
            if (rise[0]) begin
                nrise++;
                if (lat == 0) lat = k;
            end
        end
        n_tests++;
        if (lat !== SYNC + 2) begin
            n_fail++;
            $display("FAIL t1_latency got %0d want %0d", lat, SYNC + 2);
        end
        n_tests++;
        if (nrise !== 1) begin
            n_fail++;
            $display("FAIL t1_rise_width got %0d want 1", nrise);
        end
    endtask

    task automatic test_t2_short_burst();
        int lat = 0, early = 0;
        thr = 4'd5;
        for (int k = 1; k <= 30; k++) begin
            if (k <= 3)       pulse[1] = 1'b1;
            else if (k == 4)  pulse[1] = 1'b0;
            else if (k <= 10) pulse[1] = 1'b1;
            else              pulse[1] = 1'b0;
            tick();
            n_tests++;
            if ({true_pulse, rise, fall, any_change} !== {e_tp, e_rise, e_fall, |(e_rise | e_fall)}) begin
                n_fail++;
                $display("FAIL t2_cycle%0d got %b/%b/%b/%b want %b/%b/%b", k, true_pulse, rise, fall, any_change, e_tp, e_rise, e_fall);
            end
            if (rise[1] && k < 5) early++;
            if (rise[1] && lat == 0 && k >= 5) lat = k - 4;
        end
        n_tests++;
        if (early !== 0 || lat !== SYNC + 5) begin
            n_fail++;
            $display("FAIL t2_burst got early=%0d lat=%0d want early=0 lat=%0d", early, lat, SYNC + 5);
        end
    endtask

    task automatic test_t3_glitch();
        int nfall = 0, drop = 0;
        thr = 4'd4;
        pulse[2] = 1'b1;
        for (int k = 1; k <= 10; k++) tick();
        n_tests++;
        if (true_pulse[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_setup got tp2=%b want 1", true_pulse[2]);
        end
        for (int k = 1; k <= 14; k++) begin
            pulse[2] = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            tick();
            n_tests++;
            if ({true_pulse, rise, fall, any_change} !== {e_tp, e_rise, e_fall, |(e_rise | e_fall)}) begin
                n_fail++;
                $display("FAIL t3_cycle%0d got %b/%b/%b/%b want %b/%b/%b", k, true_pulse, rise, fall, any_change, e_tp, e_rise, e_fall);
            end
            if (fall[2]) nfall++;
            if (!true_pulse[2]) drop++;
        end
        n_tests++;
        if (nfall !== 0 || drop !== 0) begin
            n_fail++;
            $display("FAIL t3_glitch got falls=%0d drops=%0d want 0/0", nfall, drop);
        end
    endtask

    task automatic test_t4_inverted();
        int lat_r = 0, lat_f = 0;
        thr = 4'd2;
        do_reset(4'b0000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_tests++;
            if ({true_pulse, rise, fall, any_change} !== {e_tp, e_rise, e_fall, |(e_rise | e_fall)}) begin
                n_fail++;
                $display("FAIL t4r_cycle%0d got %b/%b/%b/%b want %b/%b/%b", k, true_pulse, rise, fall, any_change, e_tp, e_rise, e_fall);
            end
            if (rise[3] && lat_r == 0) lat_r = k;
        end
        pulse[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (fall[3] && lat_f == 0) lat_f = k;
        end
        n_tests++;
        if (lat_r !== SYNC + 2 || lat_f !== SYNC + 2) begin
            n_fail++;
            $display("FAIL t4_latency got rise=%0d fall=%0d want %0d/%0d", lat_r, lat_f, SYNC + 2, SYNC + 2);
        end
    endtask

    task automatic test_t5_hold();
        int strobes = 0, lat = 0;
        do_reset(IDLE);
        thr = 4'd3;
        pulse[0] = 1'b1;
        repeat (SYNC + 1) tick();
        en = 1'b0;
        thr = 4'd9;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (rise != 0 || fall != 0) strobes++;
            n_tests++;
            if (true_pulse[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL t5_hold_tp got %b want 0", true_pulse[0]);
            end
        end
        n_tests++;
        if (strobes !== 0) begin
            n_fail++;
            $display("FAIL t5_hold_strobes got %0d want 0", strobes);
        end
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_tests++;
            if ({true_pulse, rise, fall, any_change} !== {e_tp, e_rise, e_fall, |(e_rise | e_fall)}) begin
                n_fail++;
                $display("FAIL t5_cycle%0d got %b/%b/%b/%b want %b/%b/%b", k, true_pulse, rise, fall, any_change, e_tp, e_rise, e_fall);
            end
            if (rise[0] && lat == 0) lat = k;
        end
        n_tests++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL t5_resume got %0d want 2", lat);
        end
    endtask

    task automatic test_t6_async_reset();
        thr = 4'd3;
        pulse = 4'b0110;
        repeat (12) tick();
        pulse = 4'b1011;
        repeat (SYNC + 1) tick();
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({true_pulse, rise, fall, any_change} !== '0) begin
            n_fail++;
            $display("FAIL t6_async got tp=%b r=%b f=%b any=%b want all 0", true_pulse, rise, fall, any_change);
        end
        model_reset();
        @(negedge clk);
        pulse = IDLE;
        repeat (2) tick();
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_tests++;
            if ({true_pulse, rise, fall, any_change} !== {e_tp, e_rise, e_fall, |(e_rise | e_fall)}) begin
                n_fail++;
                $display("FAIL t6_cycle%0d got %b/%b/%b/%b want %b/%b/%b", k, true_pulse, rise, fall, any_change, e_tp, e_rise, e_fall);
            end
        end
    endtask

    task automatic test_thr_bounds();
        int lat0 = 0, lat15 = 0;
        do_reset(IDLE);
        thr = 4'd0;
        pulse[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rise[1] && lat0 == 0) lat0 = k;
        end
        thr = 4'd15;
        pulse[2] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            n_tests++;
            if ({true_pulse, rise, fall, any_change} !== {e_tp, e_rise, e_fall, |(e_rise | e_fall)}) begin
                n_fail++;
                $display("FAIL thrmax_cycle%0d got %b/%b/%b/%b want %b/%b/%b", k, true_pulse, rise, fall, any_change, e_tp, e_rise, e_fall);
            end
            if (rise[2] && lat15 == 0) lat15 = k;
        end
        n_tests++;
        if (lat0 !== SYNC + 2 || lat15 !== SYNC + 15) begin
            n_fail++;
            $display("FAIL thr_bounds got thr0=%0d thr15=%0d want %0d/%0d", lat0, lat15, SYNC + 2, SYNC + 15);
        end
    endtask

    task automatic test_random();
        do_reset(IDLE);
        for (int k = 1; k <= 3000; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) pulse[c] = ~pulse[c];
            if ($urandom_range(0, 30) == 0) thr = CNT_W'($urandom_range(0, 7));
            en = ($urandom_range(0, 9) != 0);
            tick();
            n_tests++;
            if ({true_pulse, rise, fall, any_change} !== {e_tp, e_rise, e_fall, |(e_rise | e_fall)}) begin
                n_fail++;
                $display("FAIL rand_cycle%0d got %b/%b/%b/%b want %b/%b/%b", k, true_pulse, rise, fall, any_change, e_tp, e_rise, e_fall);
            end
        end
        en = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_t1_step();
        test_t2_short_burst();
        test_t3_glitch();
        test_t4_inverted();
        test_t5_hold();
        test_t6_async_reset();
        test_thr_bounds();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
